// File: rtl/bit_packer.sv
// Variable-length MSB-first bit writer: packs 0..IN_W-bit codes into big-endian
// OUT_BYTES-wide words behind a valid/ready handshake, with flush of the partial tail.
module bit_packer #(
  parameter int IN_W      = 32,
  parameter int OUT_BYTES = 8,
  parameter int CNT_W     = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_W-1:0]                in_val,
  input  logic [$clog2(IN_W+1)-1:0]      in_len,
  input  logic                           flush,
  output logic                           flush_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [8*OUT_BYTES-1:0]         out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_nbytes,
  output logic [CNT_W-1:0]               total_byte_size,
  output logic                           busy
);

  localparam int OUT_W  = 8 * OUT_BYTES;
  localparam int ACC_W  = OUT_W + IN_W;
  localparam int LEN_W  = $clog2(IN_W + 1);
  localparam int NB_W   = $clog2(OUT_BYTES + 1);
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
  localparam logic [LEN_W-1:0]  IN_W_L   = LEN_W'(IN_W);
  localparam logic [IN_W:0]     ONE_WIDE = {{IN_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [FILL_W-1:0]  fill, fill_next;
  logic               out_valid_next;
  logic [OUT_W-1:0]   out_data_next;
  logic [NB_W-1:0]    out_nbytes_next;
  logic [CNT_W-1:0]   total_next;

  logic [LEN_W-1:0]   len_c;
  logic [IN_W:0]      mask_wide;
  logic [IN_W-1:0]    code_lj;
  logic [ACC_W-1:0]   ins;
  logic               free, accept, move_full, move_tail;

  // Clamp the length, then drop any bits at or above it so stray upper bits
  // never reach the stream; left-justify so the code lands just below fill.
  assign len_c     = (in_len > IN_W_L) ? IN_W_L : in_len;
  assign mask_wide = (ONE_WIDE << len_c) - ONE_WIDE;
  assign code_lj   = (in_val & mask_wide[IN_W-1:0]) << (IN_W_L - len_c);
  assign ins       = {code_lj, {OUT_W{1'b0}}} >> fill;

  assign free      = !out_valid || out_ready;
  assign in_ready  = reset_n && (state == RUN) && (fill < OUT_W_F);
  assign accept    = in_valid && in_ready;
  assign move_full = (fill >= OUT_W_F) && free;
  assign move_tail = (state == FLUSH) && (fill != '0) && (fill < OUT_W_F) && free;

  assign flush_done = reset_n && (state == DONE) && !out_valid;
  assign busy       = reset_n && ((state != RUN) || (fill != '0) || out_valid);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next      = state;
    acc_next        = acc;
    fill_next       = fill;
    out_valid_next  = out_valid;
    out_data_next   = out_data;
    out_nbytes_next = out_nbytes;
    total_next      = total_byte_size;

    if (out_valid && out_ready) begin
      out_valid_next = 1'b0;
      total_next     = total_byte_size + CNT_W'(out_nbytes);
    end

    // A move may refill the output register in the same cycle it is drained.
    if (move_full) begin
      out_valid_next  = 1'b1;
      out_data_next   = acc[ACC_W-1 -: OUT_W];
      out_nbytes_next = NB_W'(OUT_BYTES);
      acc_next        = acc << OUT_W;
      fill_next       = fill - OUT_W_F;
    end else if (move_tail) begin
      out_valid_next  = 1'b1;
      out_data_next   = acc[ACC_W-1 -: OUT_W];
      out_nbytes_next = NB_W'((fill + FILL_W'(7)) >> 3);
      acc_next        = '0;
      fill_next       = '0;
    end

    if (accept) begin
      acc_next  = acc | ins;
      fill_next = fill + FILL_W'(len_c);
    end

    case (state)
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if (fill == '0) state_next = DONE;
      DONE:    if (!out_valid) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= RUN;
      acc             <= '0;
      fill            <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_nbytes      <= '0;
      total_byte_size <= '0;
    end else begin
      state           <= state_next;
      acc             <= acc_next;
      fill            <= fill_next;
      out_valid       <= out_valid_next;
      out_data        <= out_data_next;
      out_nbytes      <= out_nbytes_next;
      total_byte_size <= total_next;
    end
  end

endmodule
